note_history_display: RTL and testbench

Keyboard-note display stage for the recorder front end. Each accepted key strobe is decoded into a compact note code and pushed into a DEPTH-slot history shift register. The history drives DEPTH pairs of active-low 7-segment digits (note letter plus accidental), newest note in slot 0. An inactivity timer blanks the whole display after HOLD_CYCLES without a valid key. The block sits between the PS/2 ASCII decoder and the HEX display pins.

---
 rtl/note_pkg.sv | 80 ++++++++
 rtl/note_history_display_if.sv | 9 +
 rtl/note_glyph.sv | 33 +++
 rtl/note_history_display.sv | 99 +++++++++
 tb/tb_note_history_display.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared note definitions: letter/accidental codes, 7-segment glyphs and the
// ASCII key decode used by both the display and the playback path.
package note_pkg;

    typedef enum logic [2:0] {
        LTR_C = 3'd0,
        LTR_D = 3'd1,
        LTR_E = 3'd2,
        LTR_F = 3'd3,
        LTR_A = 3'd4,
        LTR_B = 3'd5,
        LTR_T = 3'd6
    } letter_t;

    typedef enum logic [1:0] {
        ACC_NAT   = 2'd0,
        ACC_FLAT  = 2'd1,
        ACC_SHARP = 2'd2
    } acc_t;

    typedef struct packed {
        logic    valid;
        letter_t letter;
        acc_t    acc;
    } note_code_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] GLY_C     = 7'b1000110;
    localparam logic [6:0] GLY_D     = 7'b1000000;
    localparam logic [6:0] GLY_E     = 7'b0000110;
    localparam logic [6:0] GLY_F     = 7'b0001110;
    localparam logic [6:0] GLY_A     = 7'b0001000;
    localparam logic [6:0] GLY_B     = 7'b0000000;
    localparam logic [6:0] GLY_T     = 7'b1111000;
    localparam logic [6:0] GLY_FLAT  = 7'b0111111;
    localparam logic [6:0] GLY_SHARP = 7'b0000011;

    function automatic note_code_t mk_note(input letter_t l, input acc_t a);
        note_code_t n;
        n.valid  = 1'b1;
        n.letter = l;
        n.acc    = a;
        return n;
    endfunction

    // Keys are laid out in triples along the keyboard rows: flat, natural, sharp.
    function automatic note_code_t decode_ascii(input logic [6:0] ascii);
        note_code_t n;
        n = '{valid: 1'b0, letter: LTR_C, acc: ACC_NAT};
        case (ascii)
            7'h51: n = mk_note(LTR_C, ACC_FLAT);   // Q
            7'h57: n = mk_note(LTR_C, ACC_NAT);    // W
            7'h45: n = mk_note(LTR_C, ACC_SHARP);  // E
            7'h52: n = mk_note(LTR_D, ACC_FLAT);   // R
            7'h54: n = mk_note(LTR_D, ACC_NAT);    // T
            7'h59: n = mk_note(LTR_D, ACC_SHARP);  // Y
            7'h55: n = mk_note(LTR_E, ACC_FLAT);   // U
            7'h49: n = mk_note(LTR_E, ACC_NAT);    // I
            7'h4F: n = mk_note(LTR_E, ACC_SHARP);  // O
            7'h50: n = mk_note(LTR_F, ACC_FLAT);   // P
            7'h41: n = mk_note(LTR_F, ACC_NAT);    // A
            7'h53: n = mk_note(LTR_F, ACC_SHARP);  // S
            7'h44: n = mk_note(LTR_A, ACC_FLAT);   // D
            7'h46: n = mk_note(LTR_A, ACC_NAT);    // F
            7'h47: n = mk_note(LTR_A, ACC_SHARP);  // G
            7'h48: n = mk_note(LTR_B, ACC_FLAT);   // H
            7'h4A: n = mk_note(LTR_B, ACC_NAT);    // J
            7'h4B: n = mk_note(LTR_B, ACC_SHARP);  // K
            7'h4C: n = mk_note(LTR_T, ACC_NAT);    // L
            default: n.valid = 1'b0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/note_history_display_if.sv
// Key strobe bus from the PS/2 ASCII decoder into the note history display.
interface note_history_display_if;
    logic       key_valid;
    logic [6:0] ascii_val;
    logic       clear;

    modport master (output key_valid, output ascii_val, output clear);
    modport slave  (input  key_valid, input  ascii_val, input  clear);
endinterface

// File: rtl/note_glyph.sv
// One history slot: stored note code to active-low letter and accidental digits.
module note_glyph
    import note_pkg::*;
(
    input  note_code_t  code,
    output logic [6:0]  note_seg,
    output logic [6:0]  sym_seg
);

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        note_seg = SEG_BLANK;
        sym_seg  = SEG_BLANK;
        if (code.valid) begin
            case (code.letter)
                LTR_C:   note_seg = GLY_C;
                LTR_D:   note_seg = GLY_D;
                LTR_E:   note_seg = GLY_E;
                LTR_F:   note_seg = GLY_F;
                LTR_A:   note_seg = GLY_A;
                LTR_B:   note_seg = GLY_B;
                LTR_T:   note_seg = GLY_T;
                default: note_seg = SEG_BLANK;
            endcase
            case (code.acc)
                ACC_FLAT:  sym_seg = GLY_FLAT;
                ACC_SHARP: sym_seg = GLY_SHARP;
                default:   sym_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/note_history_display.sv
// Key history shift register with idle auto-blank, driving DEPTH pairs of
// 7-segment digits; newest note in slot 0.
module note_history_display
    import note_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                   clock,
    input  logic                   resetn,
    note_history_display_if.slave  key_bus,
    output logic [7*DEPTH-1:0]     note_seg,
    output logic [7*DEPTH-1:0]     sym_seg,
    output logic [3:0]             count,
    output logic                   active
);

    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] TIMER_TERM = TW'(HOLD_CYCLES - 1);

    disp_state_t     state_q, state_d;
    note_code_t      slots_q [DEPTH];
    note_code_t      new_code;
    logic [TW-1:0]   timer_q;
    logic [3:0]      count_q;
    logic            accept, do_push, do_blank, do_tick;

    assign new_code = decode_ascii(key_bus.ascii_val);
    assign accept   = key_bus.key_valid && new_code.valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // clear beats a key; an accepted key beats the timeout.
    always_comb begin
        state_d  = state_q;
        do_push  = 1'b0;
        do_blank = 1'b0;
        do_tick  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!key_bus.clear && accept) begin
                    do_push = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (key_bus.clear) begin
                    do_blank = 1'b1;
                    state_d  = ST_IDLE;
                end else if (accept) begin
                    do_push = 1'b1;
                end else if (timer_q == TIMER_TERM) begin
                    do_blank = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    do_tick = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the slot array is only DEPTH registers and must read as empty out of
    // reset, so it is reset like ordinary state rather than left as memory.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) slots_q[k] <= '0;
            timer_q <= '0;
            count_q <= '0;
        end else if (do_blank) begin
            for (int k = 0; k < DEPTH; k++) slots_q[k] <= '0;
            timer_q <= '0;
            count_q <= '0;
        end else if (do_push) begin
            // NOTE: non-blocking assignments let every slot sample its neighbour's old value.
            for (int k = DEPTH - 1; k >= 1; k--) slots_q[k] <= slots_q[k-1];
            slots_q[0] <= new_code;
            timer_q    <= '0;
            if (count_q < 4'(DEPTH)) count_q <= count_q + 4'd1;
        end else if (do_tick) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        note_glyph u_glyph (
            .code     (slots_q[k]),
            .note_seg (note_seg[7*k +: 7]),
            .sym_seg  (sym_seg[7*k +: 7])
        );
    end

    assign count  = count_q;
    assign active = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_note_history_display.sv
// Directed bench for note_history_display with DEPTH=3, HOLD_CYCLES=10.
module tb_note_history_display;

    localparam int DEPTH = 3;
    localparam int HOLD  = 10;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b1000000;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000000;
    localparam logic [6:0] GT = 7'b1111000;
    localparam logic [6:0] FL = 7'b0111111;
    localparam logic [6:0] SH = 7'b0000011;

    logic                 clock;
    logic                 resetn;
    logic [7*DEPTH-1:0]   note_seg;
    logic [7*DEPTH-1:0]   sym_seg;
    logic [3:0]           count;
    logic                 active;
    int                   n_checks;
    int                   n_pass;

    note_history_display_if key_bus ();

    note_history_display #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .key_bus  (key_bus.slave),
        .note_seg (note_seg),
        .sym_seg  (sym_seg),
        .count    (count),
        .active   (active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [6:0] a);
        key_bus.key_valid = 1'b1;
        key_bus.ascii_val = a;
        step();
        key_bus.key_valid = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [20:0] en, input logic [20:0] es,
                             input logic [3:0] ec, input logic ea);
        check({tag, ".note"},   32'(note_seg), 32'(en));
        check({tag, ".sym"},    32'(sym_seg),  32'(es));
        check({tag, ".count"},  32'(count),    32'(ec));
        check({tag, ".active"}, 32'(active),   32'(ea));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetn   = 1'b0;
        key_bus.key_valid = 1'b0;
        key_bus.ascii_val = 7'd0;
        key_bus.clear     = 1'b0;
        #12;
        check_all("reset", {BL, BL, BL}, {BL, BL, BL}, 4'd0, 1'b0);
        resetn = 1'b1;
        step();

        // Unrecognised key in IDLE does nothing.
        push(7'd90);
        check_all("z_idle", {BL, BL, BL}, {BL, BL, BL}, 4'd0, 1'b0);

        push(7'd87);  // W
        check_all("w", {BL, BL, GC}, {BL, BL, BL}, 4'd1, 1'b1);

        // key_valid held across four cycles: one push per cycle.
        key_bus.key_valid = 1'b1;
        key_bus.ascii_val = 7'd81; step();  // Q
        check("hold.count_q", 32'(count), 32'd2);
        key_bus.ascii_val = 7'd89; step();  // Y
        key_bus.ascii_val = 7'd75; step();  // K
        key_bus.ascii_val = 7'd76; step();  // L
        key_bus.key_valid = 1'b0;
        check_all("qykl", {GD, GB, GT}, {SH, SH, BL}, 4'd3, 1'b1);

        // Idle after L; unrecognised Z at timer=5 must not restart the timer.
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) begin
                key_bus.key_valid = 1'b1;
                key_bus.ascii_val = 7'd90;
            end
            step();
            key_bus.key_valid = 1'b0;
            if (i == 6) check_all("z_active", {GD, GB, GT}, {SH, SH, BL}, 4'd3, 1'b1);
            if (i == 9) check("tmo.pre_active", 32'(active), 32'd1);
        end
        check_all("timeout", {BL, BL, BL}, {BL, BL, BL}, 4'd0, 1'b0);

        // Key on the terminal cycle keeps ACTIVE and restarts the timer.
        push(7'd87);  // W
        for (int i = 1; i <= 9; i++) step();
        check("term.pre_active", 32'(active), 32'd1);
        push(7'd71);  // G, sampled on the terminal cycle
        check_all("term_key", {BL, GC, GA}, {BL, BL, SH}, 4'd2, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 9) check("term.hold_active", 32'(active), 32'd1);
        end
        check_all("term_blank", {BL, BL, BL}, {BL, BL, BL}, 4'd0, 1'b0);

        // clear together with E: clear wins, key dropped.
        push(7'd82);  // R
        check_all("r", {BL, BL, GD}, {BL, BL, FL}, 4'd1, 1'b1);
        key_bus.clear     = 1'b1;
        key_bus.key_valid = 1'b1;
        key_bus.ascii_val = 7'd69;
        step();
        key_bus.clear     = 1'b0;
        key_bus.key_valid = 1'b0;
        check_all("clear_e", {BL, BL, BL}, {BL, BL, BL}, 4'd0, 1'b0);

        // Asynchronous reset mid-cycle with three slots full.
        push(7'd81);  // Q
        push(7'd87);  // W
        push(7'd69);  // E
        check_all("full", {GC, GC, GC}, {FL, BL, SH}, 4'd3, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_all("async_rst", {BL, BL, BL}, {BL, BL, BL}, 4'd0, 1'b0);
        #3;
        resetn = 1'b1;
        push(7'd85);  // U
        check_all("post_rst", {BL, BL, GE}, {BL, BL, FL}, 4'd1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
